hilo_divider: RTL and testbench
===============================

# hilo_divider

Multi-cycle signed/unsigned integer divider that is the execute-stage consumer of the controller's DIV/DIVU decode. It accepts operands from the E stage, stalls the pipeline while iterating, and returns a {HI, LO} = {remainder, quotient} pair. That pair travels down the pipeline alongside `write_hilo` for the M/W-stage HI/LO write. It is a radix-2 restoring divider with one quotient bit per cycle.

## Interface
- `WIDTH`, default 32: operand width. The result is 2*WIDTH bits.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: E-stage instruction is DIV/DIVU. It is held high for as long as that instruction sits in E.
- `signed_div`, input, 1: 1 selects DIV (signed), 0 selects DIVU. Sampled with `start` in IDLE.
- `a`, input, WIDTH: dividend. Sampled in IDLE when `start` is high.
- `b`, input, WIDTH: divisor. Sampled in IDLE when `start` is high.
- `annul`, input, 1: cancels the division in flight. Driven by E-stage flush or exception.
- `stall_div`, output, 1: to the hazard unit. Freezes the F/D/E stages.
- `ready`, output, 1: one-cycle pulse; `result` is valid.
- `result`, output, 2*WIDTH: {HI = remainder, LO = quotient}.

## Operation
- The state machine has three states: IDLE, BUSY, DONE.
- **IDLE**
  - Condition for capture: `start` is high and `annul` is low.
  - On capture, latch the operand magnitudes, sign(a), sign(a) XOR sign(b), and `signed_div`.
  - Clear the iteration counter and the partial remainder, then go to BUSY.
  - If `start` and `annul` are both high, nothing is captured and the state stays IDLE.
- **BUSY**
  - Each cycle, shift {rem, quot} left by one. Trial-subtract |b| from the upper WIDTH+1 bits.
  - If the difference is non-negative, keep it and set the quotient LSB to 1.
  - After WIDTH iterations, go to DONE.
- **DONE**
  - Apply sign fix-up: negate the quotient if the signs differed; negate the remainder if the dividend was negative.
  - Register the result into `result`, pulse `ready`, and go to IDLE.
- **Unsigned mode**: magnitudes equal the raw operands; no fix-up is applied.
- **Divide by zero** (b == 0) in either mode:
  - Skip iteration: go IDLE -> DONE directly.
  - LO = all ones; HI = a, unmodified.
- **Signed overflow** (a = -2^(WIDTH-1), b = -1): LO = 0x80000000, HI = 0. This is the natural two's-complement wrap; it needs no special case beyond correct WIDTH+1-bit arithmetic.
- **`annul`** in BUSY or DONE: return to IDLE on the next edge.
  - No `ready` pulse.
  - `result` is unchanged.
  - `stall_div` deasserts in that same cycle.
- `result` holds its last value until the next DONE.

## Timing
- Reset values: state = IDLE, `stall_div` = 0, `ready` = 0, `result` = 0. Reset takes effect immediately, including mid-division; the partial result is discarded.
- `stall_div` = (state == IDLE and `start` and not `annul`) OR state == BUSY. It is combinational from `start` in IDLE so that the stall begins in the capture cycle.
- In DONE, `stall_div` = 0 and `ready` = 1, so the E stage advances on that edge carrying `result`.
- Latency, with the capture cycle counted as 0:
  - BUSY occupies cycles 1..WIDTH.
  - DONE (`ready` high) is cycle WIDTH+1, i.e. 33 for WIDTH = 32.
  - Divide by zero: `ready` is at cycle 1.
- `start` is still high in the DONE cycle for the same instruction. It is ignored there because DONE always returns to IDLE.
- Back-to-back: a new division is captured in the first IDLE cycle after DONE, when `start` is high for the next instruction.
- The iteration counter is $clog2(WIDTH)+1 bits wide and must not wrap before reaching WIDTH.

## Test plan
- **DIVU 7 / 2**: `ready` at cycle 33, `result` = {0x00000001, 0x00000003}. `stall_div` is high for cycles 0..32 and low at 33.
- **DIV -7 / 2**: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- **DIV 7 / -2**: LO = 0xFFFFFFFD, HI = 0x00000001.
- **DIV 0x80000000 / 0xFFFFFFFF**: LO = 0x80000000, HI = 0.
- **DIVU 0xFFFFFFFF / 1**: LO = 0xFFFFFFFF, HI = 0.
- **Divide by zero, DIV 5 / 0**: `ready` at cycle 1, LO = 0xFFFFFFFF, HI = 5, `stall_div` high only in cycle 0.
- **`annul` at cycle 10 of a division**: state is IDLE at cycle 11, no `ready` pulse, `result` keeps its prior value. A new `start` at cycle 12 completes normally at cycle 45.
- **`rst` low at cycle 20**: all outputs are 0 immediately. After release, a new DIVU 100 / 7 yields {2, 14} 33 cycles after capture.

Source files
------------

// File: rtl/hilo_divider.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// result = {HI = remainder, LO = quotient}, stalls the front end while busy.
module hilo_divider #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               annul,
    output logic               stall_div,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   mag_b, rem, quot;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic [CW-1:0]      cnt;
    logic               neg_q, neg_r;
    logic [2*WIDTH-1:0] result_q;
    logic [WIDTH:0]     shifted, diff;
    logic               capture, last_iter, sign_a, sign_b;

    assign capture   = (state == IDLE) && start && !annul;
    assign sign_a    = signed_div & a[WIDTH-1];
    assign sign_b    = signed_div & b[WIDTH-1];
    assign shifted   = {rem, quot[WIDTH-1]};
    assign diff      = shifted - {1'b0, mag_b};
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign res_lo    = neg_q ? -quot : quot;
    assign res_hi    = neg_r ? -rem : rem;

    // The final value is visible in the DONE cycle itself so the E stage
    // can carry it forward on the same edge; afterwards the register holds it.
    assign result    = ready ? {res_hi, res_lo} : result_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall_div = 1'b0;
        ready     = 1'b0;
        case (state)
            IDLE: if (capture) begin
                stall_div = 1'b1;
                state_nxt = (b == '0) ? DONE : BUSY;
            end
            BUSY: if (annul) begin
                state_nxt = IDLE;
            end else begin
                stall_div = 1'b1;
                if (last_iter) state_nxt = DONE;
            end
            DONE: begin
                ready     = !annul;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!rst) stall_div = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mag_b    <= '0;
            rem      <= '0;
            quot     <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_q <= '0;
        end else begin
            if (capture) begin
                cnt   <= '0;
                mag_b <= sign_b ? -b : b;
                if (b == '0) begin
                    // Divide by zero bypasses iteration and fix-up entirely.
                    rem   <= a;
                    quot  <= '1;
                    neg_q <= 1'b0;
                    neg_r <= 1'b0;
                end else begin
                    rem   <= '0;
                    quot  <= sign_a ? -a : a;
                    neg_q <= sign_a ^ sign_b;
                    neg_r <= sign_a;
                end
            end else if (state == BUSY) begin
                cnt <= cnt + 1'b1;
                if (!diff[WIDTH]) begin
                    rem  <= diff[WIDTH-1:0];
                    quot <= {quot[WIDTH-2:0], 1'b1};
                end else begin
                    rem  <= shifted[WIDTH-1:0];
                    quot <= {quot[WIDTH-2:0], 1'b0};
                end
            end
            if (ready) result_q <= {res_hi, res_lo};
        end
    end
endmodule

// File: tb/tb_hilo_divider.sv
// Self-checking bench for hilo_divider: scoreboard of expected {HI,LO}
// pairs, per-cycle stall/latency checks, annul and reset scenarios.
module tb_hilo_divider;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, signed_div, annul;
    logic [31:0] a, b;
    logic        stall_div, ready;
    logic [63:0] result;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] sb_q[$];
    logic [63:0] last_exp;

    hilo_divider #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
        .a(a), .b(b), .annul(annul),
        .stall_div(stall_div), .ready(ready), .result(result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [31:0] uq, ur;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            q  = sx / sy;
            r  = sx % sy;
            return {r[31:0], q[31:0]};
        end
        uq = x / y;
        ur = x % y;
        return {ur, uq};
    endfunction

    // Starts a division in the current cycle (cycle 0) and follows it to ready.
    // Leaves the bench in the first IDLE cycle after DONE with start still high.
    task automatic run_one(input bit s, input logic [31:0] x, input logic [31:0] y,
                           input logic [63:0] expv, input string name);
        int lat;
        bit got;
        logic [63:0] e;
        lat = (y == 32'd0) ? 1 : 33;
        sb_q.push_back(expv);
        start = 1'b1; signed_div = s; a = x; b = y; annul = 1'b0;
        got = 1'b0;
        for (int c = 0; c <= 40 && !got; c++) begin
            #1;
            checks++;
            if (stall_div !== (c < lat)) begin
                errors++;
                $display("FAIL %s stall c=%0d got=%b exp=%b", name, c, stall_div, (c < lat));
            end
            if (ready === 1'b1) begin
                got = 1'b1;
                checks++;
                if (c != lat) begin
                    errors++;
                    $display("FAIL %s latency got=%0d exp=%0d", name, c, lat);
                end
                e = sb_q.pop_front();
                last_exp = e;
                checks++;
                if (result !== e) begin
                    errors++;
                    $display("FAIL %s result got=%h exp=%h", name, result, e);
                end
            end
            tick();
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL %s timeout no ready", name);
            void'(sb_q.pop_front());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; signed_div = 1'b0; a = 32'd9; b = 32'd2; annul = 1'b0;
        #2;
        checks++;
        if (stall_div !== 1'b0 || ready !== 1'b0 || result !== 64'd0) begin
            errors++;
            $display("FAIL reset_state got stall=%b ready=%b result=%h exp 0/0/0", stall_div, ready, result);
        end
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_divu();
        run_one(1'b0, 32'd7, 32'd2, {32'h1, 32'h3}, "divu_7_2");
        start = 1'b0;
        tick();
        run_one(1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, "divu_max_1");
        start = 1'b0;
        tick();
    endtask

    task automatic test_signed();
        run_one(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_m7_2");
        start = 1'b0; tick();
        run_one(1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, "div_7_m2");
        start = 1'b0; tick();
        run_one(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, "div_ovf");
        start = 1'b0; tick();
    endtask

    task automatic test_div_zero();
        run_one(1'b1, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, "div_5_0");
        start = 1'b0; tick();
        run_one(1'b1, 32'hFFFF_FF00, 32'd0, {32'hFFFF_FF00, 32'hFFFF_FFFF}, "div_neg_0");
        start = 1'b0; tick();
    endtask

    task automatic test_annul();
        logic [63:0] prev;
        prev = last_exp;
        start = 1'b1; signed_div = 1'b0; a = 32'd1000; b = 32'd3; annul = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        annul = 1'b1;
        #1;
        checks++;
        if (stall_div !== 1'b0 || ready !== 1'b0 || result !== prev) begin
            errors++;
            $display("FAIL annul_busy got stall=%b ready=%b result=%h exp 0/0/%h", stall_div, ready, result, prev);
        end
        tick();
        start = 1'b0; annul = 1'b0;
        #1;
        checks++;
        if (stall_div !== 1'b0 || ready !== 1'b0 || result !== prev) begin
            errors++;
            $display("FAIL annul_idle got stall=%b ready=%b result=%h exp 0/0/%h", stall_div, ready, result, prev);
        end
        tick();
        run_one(1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, "after_annul");
        start = 1'b0; tick();
        // Annul landing on the DONE cycle must suppress ready and keep result.
        prev = last_exp;
        start = 1'b1; signed_div = 1'b0; a = 32'd9; b = 32'd0;
        tick();
        annul = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0 || result !== prev) begin
            errors++;
            $display("FAIL annul_done got ready=%b result=%h exp 0/%h", ready, result, prev);
        end
        tick();
        start = 1'b0; annul = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || result !== prev) begin
            errors++;
            $display("FAIL annul_hold got ready=%b result=%h exp 0/%h", ready, result, prev);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        start = 1'b1; signed_div = 1'b0; a = 32'hFFFF_0000; b = 32'd3; annul = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        rst = 1'b0;
        #1;
        checks++;
        if (stall_div !== 1'b0 || ready !== 1'b0 || result !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid got stall=%b ready=%b result=%h exp 0/0/0", stall_div, ready, result);
        end
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        checks++;
        if (stall_div !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got stall=%b ready=%b exp 0/0", stall_div, ready);
        end
        run_one(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, "divu_100_7");
        start = 1'b0; tick();
    endtask

    task automatic test_back_to_back();
        bit s;
        logic [31:0] x, y;
        for (int i = 0; i < 6; i++) begin
            s = 1'($urandom_range(0, 1));
            x = $urandom;
            case (i % 3)
                0: y = $urandom;
                1: y = $urandom_range(1, 100);
                default: y = -$urandom_range(1, 100);
            endcase
            if (i == 3) y = 32'd0;
            run_one(s, x, y, ref_div(s, x, y), "b2b");
        end
        start = 1'b0; tick();
    endtask

    initial begin
        last_exp = 64'd0;
        test_reset();
        test_divu();
        test_signed();
        test_div_zero();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
